// File: rtl/reg_cmd_responder.sv
// Byte-stream register command responder: 8-byte frames drive register write/read strobes, readback returned as 4 reply bytes.
// Optional build macro CMD_TIMEOUT_EN abandons a partial frame after TIMEOUT_CYCLES idle cycles.
module reg_cmd_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [31:0] reg_rdata,
  output logic [7:0]  reply_data,
  output logic        reply_valid,
  input  logic        reply_ready
);

  localparam logic [7:0] MAGIC = 8'hAA;

  typedef enum logic [3:0] {
    S_IDLE, S_FLAG, S_ADDR0, S_ADDR1, S_VAL0, S_VAL1, S_VAL2, S_VAL3,
    S_EXEC, S_READ, S_CAPTURE, S_REPLY
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        wr_flag_q, wr_flag_d;
  logic [15:0] reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_rd_q, reg_rd_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        reply_valid_q, reply_valid_d;
  logic [7:0]  reply_data_q, reply_data_d;
  logic [31:0] reply_sr_q, reply_sr_d;
  logic [1:0]  reply_cnt_q, reply_cnt_d;
  logic        accept;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  assign accept = cmd_valid & cmd_ready_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    wr_flag_d     = wr_flag_q;
    reg_addr_d    = reg_addr_q;
    reg_wdata_d   = reg_wdata_q;
    reg_wr_d      = 1'b0;
    reg_rd_d      = 1'b0;
    reply_valid_d = reply_valid_q;
    reply_data_d  = reply_data_q;
    reply_sr_d    = reply_sr_q;
    reply_cnt_d   = reply_cnt_q;
`ifdef CMD_TIMEOUT_EN
    to_d          = '0;
`endif

    case (state_q)
      S_IDLE:  if (accept && cmd_data == MAGIC) state_d = S_FLAG;
      S_FLAG:  if (accept) begin wr_flag_d = cmd_data[0]; state_d = S_ADDR0; end
      S_ADDR0: if (accept) begin reg_addr_d[7:0] = cmd_data; state_d = S_ADDR1; end
      S_ADDR1: if (accept) begin reg_addr_d[15:8] = cmd_data; state_d = S_VAL0; end
      S_VAL0:  if (accept) begin reg_wdata_d[7:0] = cmd_data; state_d = S_VAL1; end
      S_VAL1:  if (accept) begin reg_wdata_d[15:8] = cmd_data; state_d = S_VAL2; end
      S_VAL2:  if (accept) begin reg_wdata_d[23:16] = cmd_data; state_d = S_VAL3; end
      S_VAL3: begin
        if (accept) begin
          reg_wdata_d[31:24] = cmd_data;
          reg_wr_d           = wr_flag_q;
          state_d            = S_EXEC;
        end
      end
      S_EXEC: begin
        reg_rd_d = 1'b1;
        state_d  = S_READ;
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        reply_sr_d    = reg_rdata;
        reply_data_d  = reg_rdata[7:0];
        reply_cnt_d   = 2'd0;
        reply_valid_d = 1'b1;
        state_d       = S_REPLY;
      end
      S_REPLY: begin
        if (reply_valid_q && reply_ready) begin
          if (reply_cnt_q == 2'd3) begin
            reply_valid_d = 1'b0;
            state_d       = S_IDLE;
          end else begin
            reply_data_d = reply_sr_q[15:8];
            reply_sr_d   = {8'h00, reply_sr_q[31:8]};
            reply_cnt_d  = reply_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef CMD_TIMEOUT_EN
    // Idle gap inside a frame: count, and abandon the frame without strobes on expiry
    if (state_q >= S_FLAG && state_q <= S_VAL3 && !accept) begin
      if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) state_d = S_IDLE;
      else                                   to_d    = to_q + TO_W'(1);
    end
`endif

    cmd_ready_d = (state_d <= S_VAL3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_flag_q     <= 1'b0;
      reg_addr_q    <= '0;
      reg_wdata_q   <= '0;
      reg_wr_q      <= 1'b0;
      reg_rd_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      reply_valid_q <= 1'b0;
      reply_data_q  <= '0;
      reply_sr_q    <= '0;
      reply_cnt_q   <= '0;
`ifdef CMD_TIMEOUT_EN
      to_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_flag_q     <= wr_flag_d;
      reg_addr_q    <= reg_addr_d;
      reg_wdata_q   <= reg_wdata_d;
      reg_wr_q      <= reg_wr_d;
      reg_rd_q      <= reg_rd_d;
      cmd_ready_q   <= cmd_ready_d;
      reply_valid_q <= reply_valid_d;
      reply_data_q  <= reply_data_d;
      reply_sr_q    <= reply_sr_d;
      reply_cnt_q   <= reply_cnt_d;
`ifdef CMD_TIMEOUT_EN
      to_q          <= to_d;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_wr      = reg_wr_q;
  assign reg_rd      = reg_rd_q;
  assign reply_data  = reply_data_q;
  assign reply_valid = reply_valid_q;

endmodule

// File: tb/tb_reg_cmd_responder.sv
// Scoreboard bench for reg_cmd_responder: directed frames push expected strobes/reply bytes, a monitor pops and compares.
module tb_reg_cmd_responder;

  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic [7:0]  reply_data;
  logic        reply_valid;
  logic        reply_ready;

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 0;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_rep[$];
  logic [31:0] mem[16];

  reg_cmd_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata),
    .reply_data(reply_data), .reply_valid(reply_valid), .reply_ready(reply_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: read data appears the cycle after reg_rd
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1]    <= 32'hCAFEF00D;
      mem[4]    <= 32'h12345678;
      reg_rdata <= 32'h0;
    end else begin
      if (reg_wr) mem[reg_addr[3:0]] <= reg_wdata;
      if (reg_rd) reg_rdata <= mem[reg_addr[3:0]];
    end
  end

  initial begin
    reply_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       reply_ready = 1'b1;
        1:       reply_ready = ~reply_ready;
        default: reply_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every strobe and every accepted reply byte with the scoreboard
  initial begin
    wr_t         w;
    logic [15:0] a;
    logic [7:0]  b;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (reg_wr) begin
          if (exp_wr.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_reg_wr: got addr %h data %h expected no write", reg_addr, reg_wdata);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(reg_addr), 32'(w.addr));
            chk("wr_data", reg_wdata, w.data);
          end
        end
        if (reg_rd) begin
          if (exp_rd.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_reg_rd: got addr %h expected no read", reg_addr);
          end else begin
            a = exp_rd.pop_front();
            chk("rd_addr", 32'(reg_addr), 32'(a));
          end
        end
        if (reply_valid && reply_ready) begin
          if (exp_rep.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_reply: got %h expected no byte", reply_data);
          end else begin
            b = exp_rep.pop_front();
            chk("reply_byte", 32'(reply_data), 32'(b));
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL cmd_accept: got cmd_ready=0 for 200 cycles expected 1 (byte %h)", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] flag, input logic [15:0] addr, input logic [31:0] val);
    send_byte(8'hAA);
    send_byte(flag);
    send_byte(addr[7:0]);
    send_byte(addr[15:8]);
    send_byte(val[7:0]);
    send_byte(val[15:8]);
    send_byte(val[23:16]);
    send_byte(val[31:24]);
    cmd_valid = 1'b0;
  endtask

  task automatic push_reply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    exp_rep.push_back(b0);
    exp_rep.push_back(b1);
    exp_rep.push_back(b2);
    exp_rep.push_back(b3);
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_wr.size() == 0 && exp_rd.size() == 0 && exp_rep.size() == 0 && cmd_ready && !reply_valid) begin
        ok = 1; break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s_done: got pending wr=%0d rd=%0d reply=%0d expected all 0", name,
               exp_wr.size(), exp_rd.size(), exp_rep.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_reply_valid", 32'(reply_valid), 32'd0);
    chk("rst_reg_wr", 32'(reg_wr), 32'd0);
    chk("rst_reg_rd", 32'(reg_rd), 32'd0);
    chk("rst_reply_data", 32'(reply_data), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_reg_wdata", reg_wdata, 32'd0);
    @(posedge clk); #1;

    // Garbage ahead of a read of 0x0001, plus minimum latency
    exp_rd.push_back(16'h0001);
    push_reply(8'h0D, 8'hF0, 8'hFE, 8'hCA);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    send_frame(8'h00, 16'h0001, 32'h0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (reply_valid) begin lat = i; break; end
    end
    chk("latency", 32'(lat), 32'd3);
    wait_done("garbage_read");

    // Write 4 to 0x0003, readback reply
    exp_wr.push_back('{addr: 16'h0003, data: 32'h00000004});
    exp_rd.push_back(16'h0003);
    push_reply(8'h04, 8'h00, 8'h00, 8'h00);
    send_frame(8'h01, 16'h0003, 32'h00000004);
    wait_done("write3");

    // Read 0x0004 with flag bits 7:1 set and reply_ready toggling
    rdy_mode = 1;
    exp_rd.push_back(16'h0004);
    push_reply(8'h78, 8'h56, 8'h34, 8'h12);
    send_frame(8'hFE, 16'h0004, 32'hFFFFFFFF);
    wait_done("toggle_read");
    rdy_mode = 0;

    // 0xAA bytes inside a frame are data
    exp_wr.push_back('{addr: 16'h00AA, data: 32'hAAAAAAAA});
    exp_rd.push_back(16'h00AA);
    push_reply(8'hAA, 8'hAA, 8'hAA, 8'hAA);
    send_frame(8'h01, 16'h00AA, 32'hAAAAAAAA);
    wait_done("magic_data");

    // Reset after 5th byte drops the frame
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h09);
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_reply_valid", 32'(reply_valid), 32'd0);
    chk("midrst_reg_addr", 32'(reg_addr), 32'd0);
    chk("midrst_reg_wdata", reg_wdata, 32'd0);
    @(posedge clk); #1;
    exp_wr.push_back('{addr: 16'h0007, data: 32'hDEADBEEF});
    exp_rd.push_back(16'h0007);
    push_reply(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_frame(8'h01, 16'h0007, 32'hDEADBEEF);
    wait_done("after_reset");

    // reply_ready held low: first byte must hold
    rdy_mode = 2;
    exp_rd.push_back(16'h0007);
    push_reply(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_frame(8'h00, 16'h0007, 32'h0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("stall_valid", 32'(reply_valid), 32'd1);
    chk("stall_data", 32'(reply_data), 32'hEF);
    rdy_mode = 0;
    wait_done("stall_read");

    // Inter-byte gap of TIMEOUT_CYCLES cycles
`ifndef CMD_TIMEOUT_EN
    exp_wr.push_back('{addr: 16'h0003, data: 32'h00000004});
    exp_rd.push_back(16'h0003);
    push_reply(8'h04, 8'h00, 8'h00, 8'h00);
`endif
    send_byte(8'hAA); send_byte(8'h01);
    cmd_valid = 1'b0;
    repeat (TO) @(posedge clk);
    #1;
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    cmd_valid = 1'b0;
    wait_done("gap");

    // A clean frame after the gap proves the block is back in IDLE
    exp_rd.push_back(16'h0001);
    push_reply(8'h0D, 8'hF0, 8'hFE, 8'hCA);
    send_frame(8'h00, 16'h0001, 32'h0);
    wait_done("post_gap");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
